// File: rtl/mem_responder.sv
// Single-port word memory behind a four-phase request/response handshake.
// A transaction is latched on capture and completes after a fixed number of edges.
module mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_request,
    input  logic [ADDR_WIDTH-1:0] locator_bus,
    input  logic                  memory_mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  memory_response,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: memory_request is a level held by the requester until it sees
    // memory_response high; the request must then drop, and the response falls
    // on the next edge. Address, mode and data are sampled only on capture.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_count;
    logic [3:0]            w_count_next;
    logic                  w_capture;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mem [0:2**ADDR_WIDTH-1];

    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (memory_request) begin
                    w_capture    = 1'b1;
                    w_count_next = 4'(LATENCY - 1);
                    w_next       = BUSY;
                end
            end
            BUSY: begin
                // A dropped request aborts regardless of the counter value.
                if (!memory_request) begin
                    w_next = IDLE;
                end else if (r_count != 4'd0) begin
                    w_count_next = r_count - 4'd1;
                end else begin
                    w_commit = 1'b1;
                    w_next   = RESPOND;
                end
            end
            RESPOND: begin
                if (!memory_request) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= 4'd0;
            memory_response <= 1'b0;
            data_out        <= '0;
        end else begin
            r_state         <= w_next;
            r_count         <= w_count_next;
            memory_response <= (w_next == RESPOND);
            if (w_commit && !r_mode) begin
                data_out <= r_mem[r_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_addr <= locator_bus;
            r_mode <= memory_mode;
            r_data <= data_in;
        end
    end

    // The array has no reset; the reset term keeps a write from landing on an
    // edge where reset is already asserted.
    always_ff @(posedge clk) begin
        if (w_commit && r_mode && !reset) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a default instance plus a
// small LATENCY=1 instance that is scanned exhaustively.
module tb_mem_responder;
    localparam int AW1  = 10;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [2];
    logic       req  [2];
    logic       mode [2];
    logic [15:0] addr [2];
    logic [7:0] din  [2];
    logic       resp [2];
    logic [7:0] dout [2];
    logic       bsy  [2];
    logic [1:0] dbg  [2];
    logic [AW1-1:0] addr1_w;
    assign addr1_w = addr[1][AW1-1:0];

    mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .memory_request(req[0]), .locator_bus(addr[0]),
        .memory_mode(mode[0]), .data_in(din[0]), .memory_response(resp[0]),
        .data_out(dout[0]), .busy(bsy[0]), .dbg_state(dbg[0])
    );

    mem_responder #(.ADDR_WIDTH(AW1), .DATA_WIDTH(8), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .memory_request(req[1]), .locator_bus(addr1_w),
        .memory_mode(mode[1]), .data_in(din[1]), .memory_response(resp[1]),
        .data_out(dout[1]), .busy(bsy[1]), .dbg_state(dbg[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word arrays plus the last value a read returned.
    logic [7:0] m0 [0:65535];
    logic [7:0] m1 [0:(1<<AW1)-1];
    logic [7:0] last_rd [2];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising memory_response consumes one expected data_out.
    logic       prev_resp [2];
    logic [7:0] mon_e;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (resp[i] === 1'b1 && prev_resp[i] !== 1'b1) begin
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: dut%0d responded with nothing expected at %0t", i, $time);
                end else begin
                    mon_e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("resp_data%0d", i), 32'(dout[i]), 32'(mon_e));
                end
            end
            prev_resp[i] = resp[i];
        end
    end

    function automatic logic [7:0] model_txn(input int which, input logic wr,
                                             input logic [15:0] a, input logic [7:0] d);
        logic [7:0] e;
        if (which == 0) begin
            if (wr) begin m0[a] = d; e = last_rd[0]; end
            else    begin e = m0[a]; last_rd[0] = e; end
        end else begin
            if (wr) begin m1[a[AW1-1:0]] = d; e = last_rd[1]; end
            else    begin e = m1[a[AW1-1:0]]; last_rd[1] = e; end
        end
        return e;
    endfunction

    // Full four-phase transaction; called between edges with the DUT idle.
    task automatic do_txn(input int which, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input int hold);
        int lat;
        int n;
        logic [7:0] e;
        lat = (which == 0) ? LAT0 : LAT1;
        e = model_txn(which, wr, a, d);
        if (which == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        req[which] = 1'b1; mode[which] = wr; addr[which] = a; din[which] = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                addr[which] = 16'($urandom);
                din[which]  = 8'($urandom);
            end
        end while (resp[which] !== 1'b1 && n < lat + 8);
        check($sformatf("latency%0d", which), 32'(n), 32'(lat + 1));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_resp", 32'(resp[which]), 32'd1);
            check("hold_data", 32'(dout[which]), 32'(e));
        end
        req[which] = 1'b0;
        @(posedge clk); #1;
        check("resp_fall", 32'(resp[which]), 32'd0);
        check("busy_idle", 32'(bsy[which]), 32'd0);
    endtask

    task automatic do_abort(input logic [15:0] a, input logic [7:0] d);
        req[0] = 1'b1; mode[0] = 1'b1; addr[0] = a; din[0] = d;
        @(posedge clk); #1;
        check("abort_busy", 32'(bsy[0]), 32'd1);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'(bsy[0]), 32'd0);
        check("abort_resp", 32'(resp[0]), 32'd0);
    endtask

    task automatic do_reset_mid(input logic [15:0] a, input logic [7:0] d);
        req[0] = 1'b1; mode[0] = 1'b1; addr[0] = a; din[0] = d;
        @(posedge clk); #1;
        check("rst_pre_busy", 32'(bsy[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        check("rst_resp", 32'(resp[0]), 32'd0);
        check("rst_dout", 32'(dout[0]), 32'd0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        req[0] = 1'b0;
        last_rd[0] = 8'h00;
        @(negedge clk);
        rst[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [15:0] ra;
    logic [7:0]  rd;
    logic        rw;
    logic [7:0]  scan_d;

    initial begin
        for (int i = 0; i < 65536; i++) m0[i] = 8'h00;
        for (int i = 0; i < (1 << AW1); i++) m1[i] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; mode[i] = 1'b0;
            addr[i] = 16'h0; din[i] = 8'h0; last_rd[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_resp", 32'(resp[i]), 32'd0);
            check("reset_dout", 32'(dout[i]), 32'd0);
            check("reset_busy", 32'(bsy[i]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;

        // Write then read, boundary addresses
        do_txn(0, 1'b1, 16'h0010, 8'hA5, 0);
        do_txn(0, 1'b0, 16'h0010, 8'h00, 0);
        do_txn(0, 1'b1, 16'hFFFF, 8'h3C, 0);
        do_txn(0, 1'b1, 16'h0000, 8'h7E, 1);
        do_txn(0, 1'b0, 16'hFFFF, 8'h00, 0);
        do_txn(0, 1'b0, 16'h0000, 8'h00, 0);
        // Abort leaves memory untouched
        do_abort(16'h0020, 8'hFF);
        do_txn(0, 1'b0, 16'h0020, 8'h00, 0);
        // Long hold in RESPOND, then back-to-back
        do_txn(0, 1'b0, 16'h0010, 8'h00, 5);
        do_txn(0, 1'b1, 16'h0030, 8'h5A, 5);
        // Reset mid-write
        do_reset_mid(16'h0040, 8'h11);
        do_txn(0, 1'b0, 16'h0040, 8'h00, 0);
        do_txn(0, 1'b0, 16'h0010, 8'h00, 0);

        // Randomized traffic over a small address pool so reads hit writes
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 2))
                0:       ra = 16'($urandom_range(0, 15));
                1:       ra = 16'hFFF0 + 16'($urandom_range(0, 15));
                default: ra = 16'($urandom);
            endcase
            rd = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                do_abort(ra, rd);
            end else begin
                do_txn(0, rw, ra, rd, $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Exhaustive scan of the small instance
        for (int a = 0; a < (1 << AW1); a++) begin
            scan_d = 8'($urandom);
            do_txn(1, 1'b1, 16'(a), scan_d, 0);
        end
        for (int a = 0; a < (1 << AW1); a++) begin
            do_txn(1, 1'b0, 16'(a), 8'h00, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue0_drained", 32'(exp_q0.size()), 32'd0);
        check("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
